muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative integer multiply/divide unit with HI/LO result registers, parametrised in operand width. It runs beside the single-cycle ALU in the EX stage and executes MULT, MULTU, DIV and DIVU over multiple cycles through a start/busy/done handshake. The pipeline stalls on `busy` and reads results from `hi`/`lo`. Direct HI/LO writes (MTHI/MTLO) go through a separate write port.

## Interface
Parameters:
- `WIDTH`, default 32: operand width and width of each of HI and LO. Must be ≥ 4 and even.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. 0 forces reset state immediately.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, `b`  in  WIDTH each  operands (dividend/divisor for divides); captured on the accepting edge.
- `flush`  in  1  synchronous abort of an operation in flight.
- `hilo_we`  in  2  bit1 writes HI, bit0 writes LO, from `wd`.
- `wd`  in  WIDTH  direct-write data.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a result commits.
- `div_by_zero`  out  1  valid with `done`; set on divide with `b == 0`.
- `hi`, `lo`  out  WIDTH each  result registers.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE → CALC on `start`:
  - latch `op`.
  - For signed ops, latch |a| and |b| plus the sign flags.
  - Load the iteration counter with WIDTH−1.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring subtract-shift.
  - When the counter reaches 0, the state goes to FIX.
- FIX → IDLE:
  - Apply the sign fix-up.
  - Write HI/LO: multiply HI = upper half, LO = lower half; divide LO = quotient, HI = remainder.
  - Pulse `done`.
- Signed divide semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80..0 / −1 gives LO = 0x80..0, HI = 0 (wraps, no flag).
- Divide by zero (any sign): HI = `a`, LO = all ones, `div_by_zero` = 1. There is no sign fix-up.
- `start` while busy is ignored; no queueing.
- `flush` while busy → IDLE on the next edge. HI/LO are unchanged, no `done`. `flush` in IDLE has no effect and also blocks `start` on that edge.
- `hilo_we` takes effect only when not busy.
  - If `hilo_we` and `start` occur on the same edge, both are accepted. The later result overwrites HI/LO.
  - `hilo_we` while busy is dropped.
- Reset: state IDLE; `busy` = 0, `done` = 0, `div_by_zero` = 0, `hi` = 0, `lo` = 0; counter and accumulator cleared. Reset mid-operation discards the operation.

## Timing
- `start` accepted at edge k:
  - `busy` is high from after edge k until edge k+WIDTH+1.
  - HI/LO update and `done` rise at edge k+WIDTH+1, with `done` high for exactly one cycle.
- Back-to-back: a new `start` can be accepted at edge k+WIDTH+1 only if presented while IDLE. Since IDLE is entered at that edge, the earliest next accept is edge k+WIDTH+2.
- `busy` is a registered output; the decode of `start` is combinational from inputs only.

## Configuration
- `MULDIV_EARLY_OUT_EN`:
  - Defined: if `b == 0` at accept, IDLE goes directly to FIX. `done` then fires at edge k+1 with results identical to the full-latency path (multiply → 0/0; divide → divide-by-zero result).
  - Undefined: every operation takes the full WIDTH+1 cycles.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`)
  - FSM state encoding
  - `HILO_WE_HI`/`HILO_WE_LO` bit positions
- Sub-module `cond_negate`: a WIDTH-parametrised conditional two's-complement negator. It is instantiated for operand absolute values and for the result fix-up.

## Test plan
(WIDTH = 32)
- MULT a=0xFFFFFFFF, b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFD, `done` at edge k+33. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFD.
- DIV a=−7 (0xFFFFFFF9), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 → LO=14, HI=2.
- DIVU a=5, b=0 → HI=5, LO=0xFFFFFFFF, `div_by_zero`=1. Latency: 33 cycles without the macro, 1 cycle with `MULDIV_EARLY_OUT_EN`.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0, `div_by_zero`=0.
- Start MULTU; at cycle 10:
  - assert `flush` → IDLE next edge, no `done`, HI/LO keep their prior values.
  - repeat with `reset`=0 → all outputs 0 immediately.
- A second `start` while busy is ignored (no second `done`). `hilo_we`=2'b11 with `wd`=0x1234 while busy is dropped; the same write while IDLE gives HI=LO=0x1234 on the next edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state codes and HI/LO write-enable bit positions.
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int HILO_WE_HI = 1;
  localparam int HILO_WE_LO = 0;
  function automatic logic is_signed_op(input logic [1:0] op);
    return op == OP_MULT || op == OP_DIV;
  endfunction
  function automatic logic is_div_op(input logic [1:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// cond_negate: two's-complement negate of the input when neg is set, pass-through otherwise.
module cond_negate #(parameter int WIDTH = 32) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  assign out = neg ? -in : in;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and start/busy/done handshake.
// Optional MULDIV_EARLY_OUT_EN: an operation with b == 0 skips the iterations and goes straight to FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, step, prod_fix;
  logic [WIDTH-1:0] dvsr, a_raw, abs_a, abs_b, quo_fix, rem_fix;
  logic [WIDTH:0] mul_sum;
  logic [WIDTH+1:0] div_diff;
  logic neg_q, neg_r, dz, div_r, sgn, accept, early;
  assign sgn = is_signed_op(op);
  assign accept = state == S_IDLE && start && !flush;
`ifdef MULDIV_EARLY_OUT_EN
  assign early = b == '0;
`else
  assign early = 1'b0;
`endif
  cond_negate #(.WIDTH(WIDTH)) u_abs_a (.neg(sgn && a[WIDTH-1]), .in(a), .out(abs_a));
  cond_negate #(.WIDTH(WIDTH)) u_abs_b (.neg(sgn && b[WIDTH-1]), .in(b), .out(abs_b));
  cond_negate #(.WIDTH(2*WIDTH)) u_prod (.neg(neg_q), .in(acc), .out(prod_fix));
  cond_negate #(.WIDTH(WIDTH)) u_quo (.neg(neg_q), .in(acc[WIDTH-1:0]), .out(quo_fix));
  cond_negate #(.WIDTH(WIDTH)) u_rem (.neg(neg_r), .in(acc[2*WIDTH-1:WIDTH]), .out(rem_fix));
  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : '0);
  assign div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, dvsr};
  assign step = !div_r ? {mul_sum, acc[WIDTH-1:1]}
              : div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
              : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      acc <= '0;
      dvsr <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      div_r <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == S_IDLE && hilo_we[HILO_WE_HI]) hi <= wd;
      if (state == S_IDLE && hilo_we[HILO_WE_LO]) lo <= wd;
      if (busy && flush) state <= S_IDLE;
      else if (accept) begin
        state <= early ? S_FIX : S_CALC;
        cnt <= CW'(WIDTH-1);
        acc <= {{WIDTH{1'b0}}, abs_a};
        dvsr <= abs_b;
        a_raw <= a;
        dz <= b == '0;
        div_r <= is_div_op(op);
        neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= sgn && a[WIDTH-1];
      end else if (state == S_CALC) begin
        acc <= step;
        cnt <= cnt - CW'(1);
        if (cnt == '0) state <= S_FIX;
      end else if (state == S_FIX) begin
        state <= S_IDLE;
        done <= 1'b1;
        div_by_zero <= dz && div_r;
        hi <= dz ? (div_r ? a_raw : '0) : (div_r ? rem_fix : prod_fix[2*WIDTH-1:WIDTH]);
        lo <= dz ? (div_r ? '1 : '0) : (div_r ? quo_fix : prod_fix[WIDTH-1:0]);
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at WIDTH = 32.
module tb_muldiv_unit;
  localparam int W = 32;
  typedef struct packed {logic [W-1:0] hi; logic [W-1:0] lo; logic dz;} res_t;
  logic clk = 0, reset = 0, start = 0, flush = 0;
  logic [1:0] op = 0, hilo_we = 0;
  logic [W-1:0] a = 0, b = 0, wd = 0;
  logic busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  int tests = 0, fails = 0;
  res_t sb[$];
  res_t cur = '0;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hilo_we(hilo_we), .wd(wd), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    longint sx, sy, q, m;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    r.dz = 1'b0;
    if (!o[1]) begin
      p = o[0] ? {32'b0, x} * {32'b0, y} : sx * sy;
      {r.hi, r.lo} = p;
    end else if (y == 0) begin
      r.hi = x;
      r.lo = '1;
      r.dz = 1'b1;
    end else begin
      q = o[0] ? longint'({32'b0, x} / {32'b0, y}) : sx / sy;
      m = o[0] ? longint'({32'b0, x} % {32'b0, y}) : sx % sy;
      r.lo = q[W-1:0];
      r.hi = m[W-1:0];
    end
    return r;
  endfunction
  function automatic int exp_lat(input logic [W-1:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    return y == 0 ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic pop_check(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_hi"}, hi, e.hi);
    check({tag, "_lo"}, lo, e.lo);
    check({tag, "_dz"}, div_by_zero, e.dz);
    check({tag, "_busy_end"}, busy, 0);
    cur = e;
  endtask
  task automatic count_done(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check(tag, seen, 0);
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input res_t e);
    int lat;
    sb.push_back(e);
    op = o; a = x; b = y; start = 1;
    @(posedge clk); #1;
    start = 0;
    check({tag, "_busy"}, busy, 1);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat(y));
    pop_check(tag);
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 0);
  endtask
  initial begin
    int lat;
    logic [1:0] ro;
    logic [W-1:0] rx, ry;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    run_op("mult", 2'b00, 32'hFFFFFFFF, 32'd3, '{32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    run_op("multu", 2'b01, 32'hFFFFFFFF, 32'd3, '{32'h00000002, 32'hFFFFFFFD, 1'b0});
    run_op("div", 2'b10, 32'hFFFFFFF9, 32'd2, '{32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    run_op("divu", 2'b11, 32'd100, 32'd7, '{32'd2, 32'd14, 1'b0});
    run_op("divu0", 2'b11, 32'd5, 32'd0, '{32'd5, 32'hFFFFFFFF, 1'b1});
    run_op("div0s", 2'b10, 32'hFFFFFFF0, 32'd0, '{32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1});
    run_op("mult0", 2'b00, 32'd7, 32'd0, '{32'd0, 32'd0, 1'b0});
    run_op("divovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, '{32'd0, 32'h80000000, 1'b0});
    run_op("divneg", 2'b10, 32'd7, 32'hFFFFFFFE, '{32'd1, 32'hFFFFFFFD, 1'b0});
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op("rnd", ro, rx, ry, model(ro, rx, ry));
    end
    // flush mid-operation: no done, HI/LO keep the previous result
    op = 2'b01; a = 32'h1234; b = 32'h5678; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check("flush_busy", busy, 0);
    count_done("flush_nodone", 40);
    check("flush_hi", hi, cur.hi);
    check("flush_lo", lo, cur.lo);
    // reset mid-operation clears outputs without waiting for a clock edge
    op = 2'b01; a = 32'h1234; b = 32'h5678; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1 reset = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dz", div_by_zero, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1;
    cur = '0;
    count_done("arst_nodone", 40);
    // second start and HI/LO write while busy are both dropped
    sb.push_back(model(2'b11, 32'd1000, 32'd9));
    op = 2'b11; a = 32'd1000; b = 32'd9; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    op = 2'b00; a = 32'd3; b = 32'd3; start = 1; hilo_we = 2'b11; wd = 32'h1234;
    @(posedge clk); #1;
    start = 0; hilo_we = 0;
    wait_done(lat);
    check("busy2_lat", lat < 0 ? -1 : lat + 5, W + 1);
    pop_check("busy2");
    count_done("busy2_nodone", 40);
    check("busy2_hi", hi, 32'd1);
    check("busy2_lo", lo, 32'd111);
    hilo_we = 2'b11; wd = 32'h1234;
    @(posedge clk); #1;
    hilo_we = 0;
    check("we_hi", hi, 32'h1234);
    check("we_lo", lo, 32'h1234);
    hilo_we = 2'b01; wd = 32'hBEEF;
    @(posedge clk); #1;
    hilo_we = 0;
    check("we_lo_only_hi", hi, 32'h1234);
    check("we_lo_only_lo", lo, 32'hBEEF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
